// File: rtl/d_ram.sv
// d_ram: single-port word RAM, zero-initialised, with a combinational read port by default.
// Defining DRAM_REG_OUT_EN registers d_out (1-cycle read latency, cleared by rst).
module d_ram #(
   parameter int unsigned ADDR_W = 19,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 524288
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] dAddr,
   input  logic [DATA_W-1:0] d_in,
   input  logic [1:0]        MEM_WRITE,
   output logic [DATA_W-1:0] d_out
);

   localparam int unsigned    IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
   localparam logic [1:0]      CMD_WRITE = 2'b10;

   // Contents start at zero and are deliberately not touched by rst.
   logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

   logic              in_range;
   logic [IDX_W-1:0]  idx;
   logic              wr_en;
   logic [DATA_W-1:0] rd_word;

   // Widened compare so DEPTH == 2**ADDR_W does not overflow the address width.
   always_comb begin
      in_range = ({1'b0, dAddr} < DEPTH_EXT);
      idx      = dAddr[IDX_W-1:0];
      wr_en    = (MEM_WRITE == CMD_WRITE) && !rst && in_range;
   end

   always_comb begin
      rd_word = '0;
      if (in_range) begin
         rd_word = mem[idx];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[idx] <= d_in;
      end
   end

`ifdef DRAM_REG_OUT_EN
   // Captures the pre-write word, so a same-address write shows up one edge later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_out <= '0;
      end else begin
         d_out <= rd_word;
      end
   end
`else
   always_comb begin
      d_out = '0;
      if (!rst) begin
         d_out = rd_word;
      end
   end
`endif

endmodule

// File: tb/tb_d_ram.sv
// tb_d_ram: directed and randomized checks of d_ram at full depth and at DEPTH=1000,
// against an associative-array model of the memory contents.
module tb_d_ram;

   localparam int unsigned ADDR_W      = 19;
   localparam int unsigned DATA_W      = 8;
   localparam int unsigned BIG_DEPTH   = 524288;
   localparam int unsigned SMALL_DEPTH = 1000;

   logic              clk = 1'b0;
   logic              rst;
   logic [ADDR_W-1:0] dAddr;
   logic [DATA_W-1:0] d_in;
   logic [1:0]        MEM_WRITE;
   logic [DATA_W-1:0] d_out_big;
   logic [DATA_W-1:0] d_out_small;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] mdl_big   [int];
   logic [7:0] mdl_small [int];

   d_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (BIG_DEPTH)
   ) u_big (
      .clk       (clk),
      .rst       (rst),
      .dAddr     (dAddr),
      .d_in      (d_in),
      .MEM_WRITE (MEM_WRITE),
      .d_out     (d_out_big)
   );

   d_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (SMALL_DEPTH)
   ) u_small (
      .clk       (clk),
      .rst       (rst),
      .dAddr     (dAddr),
      .d_in      (d_in),
      .MEM_WRITE (MEM_WRITE),
      .d_out     (d_out_small)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] exp_big(input int a);
      if (a < int'(BIG_DEPTH) && mdl_big.exists(a)) return mdl_big[a];
      return 8'h00;
   endfunction

   function automatic logic [7:0] exp_small(input int a);
      if (a < int'(SMALL_DEPTH) && mdl_small.exists(a)) return mdl_small[a];
      return 8'h00;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Read both instances at addr; the registered build needs one edge to present the word.
   task automatic check_read(input int addr, input string tag);
      dAddr     = ADDR_W'(addr);
      MEM_WRITE = 2'b00;
`ifdef DRAM_REG_OUT_EN
      @(posedge clk);
      #1;
`else
      #1;
`endif
      check({tag, "_big"}, d_out_big, exp_big(addr));
      check({tag, "_small"}, d_out_small, exp_small(addr));
   endtask

   // One clock edge with the given command; the model applies a write only if it is legal.
   task automatic step(input int addr, input logic [7:0] data, input logic [1:0] cmd);
      dAddr     = ADDR_W'(addr);
      d_in      = data;
      MEM_WRITE = cmd;
      @(posedge clk);
      if (cmd == 2'b10 && !rst) begin
         if (addr < int'(BIG_DEPTH))   mdl_big[addr]   = data;
         if (addr < int'(SMALL_DEPTH)) mdl_small[addr] = data;
      end
      #1;
      MEM_WRITE = 2'b00;
   endtask

   function automatic int pick_addr();
      case ($urandom_range(0, 3))
         0:       return int'($urandom_range(0, 15));
         1:       return int'($urandom_range(995, 1005));
         2:       return int'($urandom_range(0, BIG_DEPTH - 1));
         default: return int'($urandom_range(BIG_DEPTH - 8, BIG_DEPTH - 1));
      endcase
   endfunction

   initial begin
      rst       = 1'b1;
      dAddr     = '0;
      d_in      = '0;
      MEM_WRITE = 2'b00;

      // Reset held: outputs zero, and a write attempted across an edge is blocked.
      #1;
      check("reset_out_big", d_out_big, 8'h00);
      check("reset_out_small", d_out_small, 8'h00);
      dAddr     = ADDR_W'(7);
      d_in      = 8'hFF;
      MEM_WRITE = 2'b10;
      @(posedge clk);
      #1;
      MEM_WRITE = 2'b00;
      check("reset_hold_big", d_out_big, 8'h00);
      #2;
      rst = 1'b0;
      check_read(7, "write_blocked_in_reset");

      // Write 20 to address 4 held for two edges, then sweep 0..10.
      step(4, 8'd20, 2'b10);
      step(4, 8'd20, 2'b10);
      for (int a = 0; a <= 10; a++) begin
         check_read(a, $sformatf("sweep_%0d", a));
      end

      // Non-write commands leave address 7 untouched.
      step(7, 8'hAA, 2'b11);
      step(7, 8'hAA, 2'b01);
      step(7, 8'hAA, 2'b00);
      check_read(7, "nowrite_cmds");

      // Same-address write and read on consecutive edges.
      dAddr     = ADDR_W'(9);
      d_in      = 8'h11;
      MEM_WRITE = 2'b10;
`ifdef DRAM_REG_OUT_EN
      @(posedge clk);
      #1;
      check("rw9_edge1", d_out_big, 8'h00);
      d_in = 8'h22;
      @(posedge clk);
      #1;
      check("rw9_edge2", d_out_big, 8'h11);
      MEM_WRITE = 2'b00;
      @(posedge clk);
      #1;
      check("rw9_edge3", d_out_big, 8'h22);
`else
      #1;
      check("rw9_pre", d_out_big, 8'h00);
      @(posedge clk);
      #1;
      check("rw9_edge1", d_out_big, 8'h11);
      d_in = 8'h22;
      @(posedge clk);
      #1;
      check("rw9_edge2", d_out_big, 8'h22);
      MEM_WRITE = 2'b00;
`endif
      mdl_big[9]   = 8'h22;
      mdl_small[9] = 8'h22;
      check_read(9, "rw9_final");

      // Reset mid-cycle: output clears at once, a write during reset is dropped, data survives.
      step(4, 8'h55, 2'b10);
      dAddr = ADDR_W'(4);
      #3;
      rst = 1'b1;
      #1;
      check("midreset_big", d_out_big, 8'h00);
      check("midreset_small", d_out_small, 8'h00);
      step(4, 8'h99, 2'b10);
      check("reset_write_big", d_out_big, 8'h00);
      #2;
      rst = 1'b0;
      check_read(4, "after_reset");

      // Top of the full-depth array, and the small instance's range boundary.
      step(BIG_DEPTH - 1, 8'h33, 2'b10);
      check_read(BIG_DEPTH - 1, "top_addr");
      step(SMALL_DEPTH, 8'h77, 2'b10);
      check_read(SMALL_DEPTH, "oob_1000");
      step(SMALL_DEPTH - 1, 8'h66, 2'b10);
      check_read(SMALL_DEPTH - 1, "edge_999");
      check_read(0, "no_alias_0");

      // Randomized traffic with occasional reset during a command.
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 15) == 0);
         step(pick_addr(), 8'($urandom), 2'($urandom_range(0, 3)));
         rst = 1'b0;
         check_read(pick_addr(), $sformatf("rand_%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
